id_reader: RTL and testbench



---
 rtl/id_reader.sv | 147 ++++++++++++++
 tb/tb_id_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_reader.sv
// id_reader: read-only initiator for the native CPU peripheral interface.
// On an accepted start it issues `count` single-word reads at consecutive
// addresses from `base_addr` and presents each returned word on a one-cycle
// result strobe. A per-read timeout aborts the run if a responder never
// acknowledges.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle run request (accepted only when idle)
//   base_addr, count    run parameters, sampled on an accepted start
//   busy                run in progress
//   done                one-cycle pulse at the end of a run (normal or aborted)
//   err                 sticky timeout flag, cleared by the next accepted start
//   res_valid           one-cycle strobe: res_addr/res_data hold a new word
//   res_addr, res_data  address and data of the last captured read
//   valid, address      bus request and address (registered)
//   wstrb               tied low, reads only
//   rdata, ready        responder read data and acknowledge
module id_reader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_data,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic              wstrb,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECOVER,
    FIN
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   idx_q;
  logic [TW-1:0]      timer_q;

  logic accept;
  logic capture;
  logic expire;

  // Next-state decode. A zero-length run is routed through RECOVER: the
  // cleared index already equals the latched count, so it falls straight to
  // FIN without touching the bus and done lands two cycles after start.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (count == '0) ? RECOVER : REQ;
        end
      end
      REQ: begin
        // An acknowledge in the final allowed cycle still wins over timeout.
        if (ready) begin
          capture = 1'b1;
          state_d = RECOVER;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          expire  = 1'b1;
          state_d = FIN;
        end
      end
      RECOVER: begin
        // ready is deliberately ignored here: responders may hold it a cycle.
        state_d = (idx_q == cnt_q) ? FIN : REQ;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
      address   <= '0;
    end else begin
      state_q   <= state_d;
      res_valid <= capture;
      timer_q   <= (state_q == REQ && !capture && !expire) ? timer_q + TW'(1) : '0;

      if (accept) begin
        base_q <= base_addr;
        cnt_q  <= count;
        idx_q  <= '0;
        err    <= 1'b0;
        if (count != '0) begin
          address <= base_addr;
        end
      end

      if (capture) begin
        res_data <= rdata;
        res_addr <= address;
        idx_q    <= idx_q + CNT_W'(1);
      end

      if (expire) begin
        err <= 1'b1;
      end

      // Address wraps modulo 2^ADDR_W; idx_q has already been advanced.
      if (state_q == RECOVER && state_d == REQ) begin
        address <= base_q + ADDR_W'(idx_q);
      end
    end
  end

  assign valid = (state_q == REQ);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == FIN);
  assign wstrb = 1'b0;

endmodule

// File: tb/tb_id_reader.sv
module tb_id_reader;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              busy, done, err, res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic              wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  always #5 clk = ~clk;

  id_reader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .res_valid(res_valid),
    .res_addr (res_addr),
    .res_data (res_data),
    .valid    (valid),
    .address  (address),
    .wstrb    (wstrb),
    .rdata    (rdata),
    .ready    (ready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Cycle counter advances on the active edge; everything else samples and
  // drives on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Responder: ready comes once valid has been seen for more than r_d
  // cycles, is held one extra cycle after valid drops, rdata = key ^ address.
  int          r_d     = 1;
  bit          r_never = 1'b0;
  logic [31:0] r_key   = '0;
  int          vcnt    = 0;
  bit          held    = 1'b0;

  // Monitor log for the current run.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                rel;
  } res_t;

  res_t              res_q[$];
  bit                mon_on      = 1'b0;
  int                start_cyc   = 0;
  int                mrel;
  int                vcount, done_cnt, done_rel, first_valid, addr_glitch;
  int                err_at_done, err_rel1, busy_rel1, post_busy;
  bit                prev_valid;
  logic [ADDR_W-1:0] prev_addr;

  task automatic clear_log();
    res_q.delete();
    vcount      = 0;
    done_cnt    = 0;
    done_rel    = -1;
    first_valid = -1;
    addr_glitch = 0;
    err_at_done = -1;
    err_rel1    = -1;
    busy_rel1   = -1;
    post_busy   = -1;
    prev_valid  = 1'b0;
    prev_addr   = '0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mrel = cyc - start_cyc;
      if (valid) begin
        vcount++;
        if (first_valid < 0) first_valid = mrel;
        if (prev_valid && address !== prev_addr) addr_glitch++;
      end
      if (res_valid) res_q.push_back('{res_addr, res_data, mrel});
      if (done) begin
        done_cnt++;
        done_rel    = mrel;
        err_at_done = int'(err);
      end
      if (mrel == 1) begin
        err_rel1  = int'(err);
        busy_rel1 = int'(busy);
      end
      if (done_rel >= 0 && mrel == done_rel + 1) post_busy = int'(busy);
      prev_valid = valid;
      prev_addr  = address;
    end
    rdata = r_key ^ {{(DATA_W-ADDR_W){1'b0}}, address};
    if (valid) begin
      vcnt++;
      held  = 1'b0;
      ready = !r_never && (vcnt > r_d);
    end else begin
      vcnt = 0;
      if (ready && !held) begin
        held = 1'b1;
      end else begin
        ready = 1'b0;
        held  = 1'b0;
      end
    end
  end

  // Reference model: whole-run outcome from the read timing rules.
  task automatic model(input logic [CNT_W-1:0] c, input int d, input bit nev,
                       output int done_r, output int e, output int vc, output int n);
    if (c == 0) begin
      done_r = 2; e = 0; vc = 0; n = 0;
    end else if (nev || d + 1 > TIMEOUT) begin
      done_r = TIMEOUT + 1; e = 1; vc = TIMEOUT; n = 0;
    end else begin
      done_r = int'(c) * (d + 2) + 1; e = 0; vc = int'(c) * (d + 1); n = int'(c);
    end
  endtask

  task automatic do_run(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c,
                        input int d, input bit nev, input logic [31:0] k, input int inj,
                        input int tbl_done, input int tbl_err, input string tag);
    int e_done, e_err, e_vc, e_n;
    int ea;
    model(c, d, nev, e_done, e_err, e_vc, e_n);
    r_d = d; r_never = nev; r_key = k;
    @(negedge clk);
    mon_on = 1'b0;
    clear_log();
    base_addr = b;
    count     = c;
    start     = 1'b1;
    start_cyc = cyc;
    mon_on    = 1'b1;
    for (int t = 1; t < 400; t++) begin
      @(negedge clk);
      if (t == inj) begin
        start = 1'b1; base_addr = ~b; count = 4'd5;
      end else begin
        start = 1'b0;
      end
      if (done_cnt > 0 && t >= done_rel + 3) break;
    end
    start  = 1'b0;
    mon_on = 1'b0;
    chk({tag, ".done_count"}, done_cnt, 1);
    chk({tag, ".done_cycle"}, done_rel, e_done);
    if (tbl_done >= 0) chk({tag, ".done_cycle_tbl"}, done_rel, tbl_done);
    chk({tag, ".err"}, err_at_done, e_err);
    if (tbl_err >= 0) chk({tag, ".err_tbl"}, err_at_done, tbl_err);
    chk({tag, ".err_cleared"}, err_rel1, 0);
    chk({tag, ".busy_c1"}, busy_rel1, 1);
    chk({tag, ".busy_after"}, post_busy, 0);
    chk({tag, ".valid_cycles"}, vcount, e_vc);
    chk({tag, ".first_valid"}, first_valid, (c != 0) ? 1 : -1);
    chk({tag, ".addr_stable"}, addr_glitch, 0);
    chk({tag, ".n_results"}, res_q.size(), e_n);
    for (int i = 0; i < e_n && i < res_q.size(); i++) begin
      ea = (int'(b) + i) % (1 << ADDR_W);
      chk($sformatf("%s.res%0d_addr", tag, i), res_q[i].a, ea);
      chk($sformatf("%s.res%0d_data", tag, i), res_q[i].d, k ^ ea);
      chk($sformatf("%s.res%0d_cycle", tag, i), res_q[i].rel, (i + 1) * (d + 2));
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] b;
    logic [CNT_W-1:0]  c;
    int                d;
    bit                nev;
    logic [31:0]       key;
    int                inj;
    int                exp_done;
    int                exp_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'd0,  4'd1,  1,  1'b0, 32'hA5A5_0001, -1, 4,  0};
    tbl[1] = '{4'd14, 4'd4,  1,  1'b0, 32'h0,         -1, 13, 0};
    tbl[2] = '{4'd5,  4'd0,  1,  1'b0, 32'h1234_0000, -1, 2,  0};
    tbl[3] = '{4'd7,  4'd3,  1,  1'b1, 32'h0,         -1, 17, 1};
    tbl[4] = '{4'd1,  4'd2,  5,  1'b0, 32'hDEAD_0000, -1, 15, 0};
    tbl[5] = '{4'd2,  4'd2,  1,  1'b0, 32'h0F0F_0000, 2,  7,  0};
    tbl[6] = '{4'd9,  4'd1,  0,  1'b0, 32'h5555_0000, 3,  3,  0};
    tbl[7] = '{4'd0,  4'd1,  15, 1'b0, 32'h7777_0000, -1, 18, 0};
    tbl[8] = '{4'd0,  4'd1,  16, 1'b0, 32'h7777_0000, -1, 17, 1};
    tbl[9] = '{4'd4,  4'd15, 0,  1'b0, 32'hCAFE_0000, -1, 31, 0};

    rst = 1'b1; start = 1'b0; base_addr = 4'hB; count = 4'h3;
    ready = 1'b0; rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.res_addr", res_addr, 0);
    chk("rst.res_data", res_data, 0);
    chk("rst.valid", valid, 0);
    chk("rst.address", address, 0);
    chk("rst.wstrb", wstrb, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle.busy", busy, 0);
    chk("idle.valid", valid, 0);

    for (int i = 0; i < 10; i++) begin
      do_run(tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].nev, tbl[i].key, tbl[i].inj,
             tbl[i].exp_done, tbl[i].exp_err, $sformatf("vec%0d", i));
    end

    // Reset during the second read request of a three-read run.
    r_d = 1; r_never = 1'b0; r_key = 32'h0;
    @(negedge clk);
    mon_on = 1'b0;
    clear_log();
    base_addr = 4'd3; count = 4'd3; start = 1'b1; start_cyc = cyc; mon_on = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstrun.req2_valid", valid, 1);
    chk("rstrun.req2_addr", address, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("rstrun.valid", valid, 0);
    chk("rstrun.busy", busy, 0);
    chk("rstrun.res_valid", res_valid, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    mon_on = 1'b0;
    chk("rstrun.no_done", done_cnt, 0);
    chk("rstrun.n_results", res_q.size(), 1);
    do_run(4'd3, 4'd3, 1, 1'b0, 32'h3C3C_0000, -1, 10, 0, "post_rst");

    for (int i = 0; i < 12; i++) begin
      logic [ADDR_W-1:0] rb;
      logic [CNT_W-1:0]  rc;
      int rd, ed, ee, ev, en, ri;
      bit rn;
      rb = ADDR_W'($urandom_range(0, 15));
      rc = CNT_W'($urandom_range(0, 5));
      rd = int'($urandom_range(0, 17));
      rn = ($urandom_range(0, 7) == 0);
      model(rc, rd, rn, ed, ee, ev, en);
      ri = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, ed)) : -1;
      do_run(rb, rc, rd, rn, $urandom, ri, -1, -1, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
